request_grant_scheduler: RTL

Downstream consumer of the 16-bit priority-encoding stage. Accumulates one-hot/multi-hot request pulses into a sticky pending vector and issues one grant per handshake, highest index first. Each grant carries the index and a flag showing whether more requests remain. Serialises bursts of simultaneous requests into an ordered index stream for a single-issue consumer.

---
 rtl/request_grant_pkg.sv | 23 ++
 rtl/request_grant_scheduler_pick.sv | 28 ++
 rtl/request_grant_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/request_grant_pkg.sv
// Shared sizing and types for the request/grant scheduler slice.
// Optional pending_count output is enabled by REQUEST_GRANT_PENDING_COUNT_EN.
package request_grant_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Index width for a request vector; a single line still needs one bit.
    function automatic int idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DEFAULT_IDX_W = idx_w(DEFAULT_WIDTH);

    typedef logic [DEFAULT_WIDTH-1:0] req_vec_t;
    typedef logic [DEFAULT_IDX_W-1:0] grant_idx_t;

    // The grant slot is either empty or holding an index for the consumer.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/request_grant_scheduler_pick.sv
// Combinational picker: highest set index of a vector, plus any-set and
// more-than-one-set flags.
module pending_highest_pick
    import request_grant_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] index,
    output logic             any,
    output logic             multi
);

    always_comb begin
        index = '0;
        // Ascending scan so the last (highest) set bit wins.
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                index = IDX_W'(i);
            end
        end
        any   = |vec;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi = |(vec & (vec - WIDTH'(1)));
    end

endmodule

// File: rtl/request_grant_scheduler.sv
// Sticky request accumulator issuing one grant per handshake, highest index first.
// Define REQUEST_GRANT_PENDING_COUNT_EN to add the registered pending_count output.
module request_grant_scheduler
    import request_grant_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_set,
    input  logic             flush,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [IDX_W-1:0] grant_index,
    output logic             grant_more,
    output logic             pending_any
`ifdef REQUEST_GRANT_PENDING_COUNT_EN
    ,
    output logic [IDX_W:0]   pending_count
`endif
);

    // Handshake: a grant transfers on a rising edge where grant_valid and
    // grant_ready are both high; grant_index/grant_more hold while valid && !ready.

    slot_state_t      state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] load_mask;
    logic [IDX_W-1:0] index_q, index_d;
    logic             more_q, more_d;
    logic [IDX_W-1:0] pick_index;
    logic             pick_any;
    logic             pick_multi;
    logic             slot_free;
    logic             load;

    pending_highest_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .vec   (pending_q),
        .index (pick_index),
        .any   (pick_any),
        .multi (pick_multi)
    );

    // Selection looks only at the registered vector, so same-cycle requests wait.
    always_comb begin
        slot_free = (state_q == ST_EMPTY) || grant_ready;
        load      = slot_free && pick_any;
        load_mask = '0;
        if (load) begin
            load_mask[pick_index] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        more_d    = more_q;
        pending_d = (pending_q & ~load_mask) | req_set;
        if (flush) begin
            state_d   = ST_EMPTY;
            pending_d = '0;
        end else if (load) begin
            state_d = ST_HOLD;
            index_d = pick_index;
            more_d  = pick_multi;
        end else if (slot_free) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            pending_q <= '0;
            index_q   <= '0;
            more_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            index_q   <= index_d;
            more_q    <= more_d;
        end
    end

    assign grant_valid = (state_q == ST_HOLD);
    assign grant_index = index_q;
    assign grant_more  = more_q;
    assign pending_any = |pending_q;

`ifdef REQUEST_GRANT_PENDING_COUNT_EN
    logic [IDX_W:0] count_d, count_q;

    always_comb begin
        count_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_d = count_d + (IDX_W + 1)'(pending_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pending_count = count_q;
`endif

endmodule
